// File: rtl/f_stage_pkg.sv
// rtl/f_stage_pkg.sv - shared fetch/decode pipeline types, constants and helpers
package f_stage_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } f_d_bus_t;

    // Decode substitutes this (addi x0,x0,0) when it squashes a transfer.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush; push into a full FIFO is allowed when popping
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !rst) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/f_stage.sv
// rtl/f_stage.sv - RV32I fetch stage: PC, pipelined imem requests, instruction buffer, redirect flush
module f_stage
    import f_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_inst,
    output logic [31:0] d_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] CAPACITY = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0] r_stale;
    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;

    logic             w_has_room;
    logic             w_req_fire;
    logic             w_drop_rsp;
    logic             w_live_rsp;
    logic [CNT_W-1:0] w_stale_on_redirect;

    logic [31:0]      w_pcq_head;
    logic [CNT_W-1:0] w_pcq_cnt;
    logic             w_pcq_empty;
    logic             w_pcq_full;

    f_d_bus_t         w_buf_push_data;
    f_d_bus_t         w_buf_head;
    logic [CNT_W-1:0] w_buf_cnt;
    logic             w_buf_empty;
    logic             w_buf_full;
    logic             w_unused;

    // Budget covers both in-flight requests and buffered entries, so a response always has a slot.
    assign w_has_room     = ({1'b0, r_inflight} + {1'b0, w_buf_cnt}) < CAPACITY;
    assign imem_req_valid = !rst && !redirect_valid && w_has_room;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // The response landing in the redirect cycle is dropped along with everything in flight.
    assign w_stale_on_redirect = r_inflight - CNT_W'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FS_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (w_stale_on_redirect != '0) ? FS_DRAIN : FS_RUN;
        end else if (r_state == FS_DRAIN && imem_rsp_valid && r_stale == CNT_W'(1)) begin
            w_state_nxt = FS_RUN;
        end
    end

    always_comb begin
        w_drop_rsp = imem_rsp_valid && (r_state == FS_DRAIN);
        w_live_rsp = imem_rsp_valid && (r_state == FS_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_stale    <= '0;
        end else begin
            r_inflight <= r_inflight + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                r_pc    <= word_align(redirect_pc);
                r_stale <= w_stale_on_redirect;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_drop_rsp) begin
                    r_stale <= r_stale - CNT_W'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_req_fire),
        .push_data (r_pc),
        .pop       (w_live_rsp),
        .pop_data  (w_pcq_head),
        .count     (w_pcq_cnt),
        .empty     (w_pcq_empty),
        .full      (w_pcq_full)
    );

    assign w_buf_push_data = '{pc: w_pcq_head, inst: imem_rsp_data};

    fetch_fifo #(
        .WIDTH ($bits(f_d_bus_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_live_rsp && !redirect_valid),
        .push_data (w_buf_push_data),
        .pop       (d_valid && d_ready),
        .pop_data  (w_buf_head),
        .count     (w_buf_cnt),
        .empty     (w_buf_empty),
        .full      (w_buf_full)
    );

    assign d_valid = !rst && !w_buf_empty;
    assign d_pc    = w_buf_head.pc;
    assign d_inst  = w_buf_head.inst;

    assign w_unused = ^{w_pcq_cnt, w_pcq_empty, w_pcq_full, w_buf_full};

endmodule

// File: tb/tb_f_stage.sv
// tb/tb_f_stage.sv - scoreboard bench for f_stage with an imem model and randomized traffic
module tb_f_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_inst;
    logic [31:0] d_pc;

    always #5 clk = ~clk;

    f_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .d_inst         (d_inst),
        .d_pc           (d_pc)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] gen_pc;
    logic [31:0] exp_head;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    bit          hold_armed;
    bit          rst_req;
    int          cyc;
    int          lat;
    int          rr_pct;
    int          dr_pct;
    int          since_redir;
    int          accepts;
    int          deliveries;
    int          checks;
    int          failures;
    int          valid_cycles;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, log the request handshake, then update the expected stream.
    task automatic step(input bit redir, input logic [31:0] tgt);
        pend_t p;
        @(negedge clk);
        cyc++;
        rst = rst_req;
        if (rst) pend_q.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
        imem_req_ready = ($urandom_range(99) < rr_pct);
        d_ready        = ($urandom_range(99) < dr_pct);
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        if (redir && !rst) check("no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            p.due  = cyc + lat;
            p.addr = imem_req_addr;
            pend_q.push_back(p);
            accepts++;
        end
        #2;
        if (rst) begin
            exp_q.delete();
            gen_pc      = 32'h0000_0000;
            since_redir = 100;
        end else if (redir) begin
            exp_q.delete();
            gen_pc      = {tgt[31:2], 2'b00};
            since_redir = 0;
        end else if (since_redir < 100) begin
            since_redir++;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_d_valid", {31'b0, d_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0000_0000);
        rst_req = 1'b0;
        accepts = 0;
    endtask

    // Monitor: every decode transfer must be the next PC of the current run from the last redirect.
    always @(negedge clk) begin
        #2;
        if (!rst && since_redir < 2) check("flush_window_d_valid", {31'b0, d_valid}, 32'd0);
        if (!rst && hold_armed) begin
            check("hold_d_valid", {31'b0, d_valid}, 32'd1);
            check("hold_d_pc", d_pc, hold_pc);
            check("hold_d_inst", d_inst, hold_inst);
        end
        if (!rst && d_valid && d_ready) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                exp_head = exp_q.pop_front();
                check("d_pc", d_pc, exp_head);
                check("d_inst", d_inst, mem_word(exp_head));
            end
            deliveries++;
        end
        hold_armed = !rst && d_valid && !d_ready && !redirect_valid;
        hold_pc    = d_pc;
        hold_inst  = d_inst;
    end

    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        d_ready        = 1'b0;
        rst_req        = 1'b1;
        hold_armed     = 1'b0;
        checks = 0; failures = 0; cyc = 0; accepts = 0; deliveries = 0;
        lat = 1; rr_pct = 100; dr_pct = 100; since_redir = 100; gen_pc = 32'h0;

        // Free run, 1-cycle memory: first request in the first cycle out of reset, 1 inst/cycle after.
        do_reset();
        step(1'b0, 32'h0);
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0000_0000);
        check("first_d_valid_c0", {31'b0, d_valid}, 32'd0);
        step(1'b0, 32'h0);
        check("first_d_valid_c1", {31'b0, d_valid}, 32'd0);
        step(1'b0, 32'h0);
        check("first_d_valid_c2", {31'b0, d_valid}, 32'd1);
        check("first_d_pc", d_pc, 32'h0000_0000);
        valid_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 32'h0);
            if (d_valid) valid_cycles++;
        end
        check("throughput_cycles", valid_cycles, 32'd30);

        // Decode stalled: exactly FIFO_DEPTH requests accepted, head held.
        do_reset();
        dr_pct = 0;
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0);
        check("stall_accepts", accepts, 32'd4);
        check("stall_d_valid", {31'b0, d_valid}, 32'd1);
        check("stall_d_pc", d_pc, 32'h0000_0000);
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        dr_pct = 100;
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        do_reset();
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0100);
        check("redir_buf_empty", {31'b0, d_valid}, 32'd0);
        step(1'b0, 32'h0);
        check("redir_req_addr", imem_req_addr, 32'h0000_0100);
        check("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0);

        // Redirect in the same cycle as the only in-flight response.
        lat = 1;
        do_reset();
        step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0300);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);

        // Unaligned target and PC wrap.
        step(1'b1, 32'h0000_0203);
        step(1'b0, 32'h0);
        check("align_req_addr", imem_req_addr, 32'h0000_0200);
        step(1'b1, 32'hFFFF_FFFC);
        step(1'b0, 32'h0);
        check("wrap_req_addr_hi", imem_req_addr, 32'hFFFF_FFFC);
        step(1'b0, 32'h0);
        check("wrap_req_addr_lo", imem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);

        // Back-to-back redirects on a 3-cycle memory.
        lat = 3;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0040);
        step(1'b1, 32'h0000_0080);
        for (int i = 0; i < 25; i++) step(1'b0, 32'h0);

        // Randomized traffic segments.
        for (int s = 0; s < 6; s++) begin
            lat    = int'($urandom_range(3, 1));
            rr_pct = int'($urandom_range(100, 40));
            dr_pct = int'($urandom_range(100, 30));
            do_reset();
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(99) < 4, $urandom);
            end
        end

        check("deliveries_seen", {31'b0, deliveries > 200}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
